alu_seq: RTL and testbench

//  Parametrised, registered successor to the team's 8-bit combinational ALU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_comb.sv | 78 +++++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, control states
// and the opcode field width.
package alu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD      = 4'h1,
    OP_SUB      = 4'h2,
    OP_INC      = 4'h3,
    OP_DEC      = 4'h4,
    OP_OR       = 4'h5,
    OP_AND      = 4'h6,
    OP_XOR      = 4'h7,
    OP_SHR      = 4'h8,
    OP_SHL      = 4'h9,
    OP_ONESCOMP = 4'hA,
    OP_TWOSCOMP = 4'hB,
    OP_MUL      = 4'hC
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the datapath and the sequential ALU.
interface alu_seq_if #(parameter int WIDTH = 8) ();
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic [OPCODE_W-1:0] opcode;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    alu_out;
  logic                alu_zero;
  logic                alu_carry;
  logic                alu_neg;
  logic                alu_ovf;
  logic                alu_err;

  modport master (
    output in_valid, in_a, in_b, opcode, out_ready,
    input  in_ready, out_valid, alu_out, alu_zero, alu_carry, alu_neg, alu_ovf, alu_err
  );

  modport slave (
    input  in_valid, in_a, in_b, opcode, out_ready,
    output in_ready, out_valid, alu_out, alu_zero, alu_carry, alu_neg, alu_ovf, alu_err
  );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU operations and their flags. MUL is produced elsewhere, so it
// yields a zero result here; unknown opcodes raise err with a zero result.
module alu_comb import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OPCODE_W-1:0] op,
  output logic [WIDTH-1:0]    res,
  output logic                zero,
  output logic                carry,
  output logic                neg,
  output logic                ovf,
  output logic                err
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] sum_s;

  // Result, carry/borrow and signed-overflow selection per opcode.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b};
    res   = ZERO;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum_s[WIDTH-1:0];
        carry = sum_s[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res   = a - b;
        carry = (a < b);
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_INC: begin
        res   = a + ONE;
        carry = (a == ONES);
        ovf   = (a == SMAX);
      end
      OP_DEC: begin
        res   = a - ONE;
        carry = (a == ZERO);
        ovf   = (a == SMIN);
      end
      OP_OR:  res = a | b;
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_SHR: begin
        res   = {1'b0, a[WIDTH-1:1]};
        carry = a[0];
      end
      OP_SHL: begin
        res   = {a[WIDTH-2:0], 1'b0};
        carry = a[MSB];
      end
      OP_ONESCOMP: res = ~a;
      OP_TWOSCOMP: begin
        res   = ~a + ONE;
        carry = (a == ZERO);
      end
      OP_MUL: res = ZERO;
      default: err = 1'b1;
    endcase
  end

  assign zero = (res == ZERO);
  assign neg  = res[MSB];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle ops go
// through alu_comb, MUL is an iterative shift-add run here.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] ZERO2  = {(2*WIDTH){1'b0}};

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic                  zero_q, zero_d, carry_q, carry_d, neg_q, neg_d;
  logic                  ovf_q, ovf_d, err_q, err_d;
  logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [WIDTH-1:0]      comb_res_s;
  logic                  comb_zero_s, comb_carry_s, comb_neg_s, comb_ovf_s, comb_err_s;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .res   (comb_res_s),
    .zero  (comb_zero_s),
    .carry (comb_carry_s),
    .neg   (comb_neg_s),
    .ovf   (comb_ovf_s),
    .err   (comb_err_s)
  );

  // Next-state, operand capture, multiply iteration and result update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d  = bus.in_a;
          b_d  = bus.in_b;
          op_d = bus.opcode;
          if (bus.opcode == OP_MUL) begin
            state_d  = ST_MUL;
            acc_d    = ZERO2;
            mcand_d  = {ZERO, bus.in_a};
            mplier_d = bus.in_b;
            cnt_d    = CNT_ZERO;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        out_d   = comb_res_s;
        zero_d  = comb_zero_s;
        carry_d = comb_carry_s;
        neg_d   = comb_neg_s;
        ovf_d   = comb_ovf_s;
        err_d   = comb_err_s;
        state_d = ST_DONE;
      end
      ST_MUL: begin
        // The counter reaching WIDTH marks the cycle that publishes the product.
        if (cnt_q == CNT_DONE) begin
          out_d   = acc_q[WIDTH-1:0];
          zero_d  = (acc_q[WIDTH-1:0] == ZERO);
          carry_d = (acc_q[2*WIDTH-1:WIDTH] != ZERO);
          neg_d   = acc_q[WIDTH-1];
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      a_q         <= ZERO;
      b_q         <= ZERO;
      op_q        <= {OPCODE_W{1'b0}};
      acc_q       <= ZERO2;
      mcand_q     <= ZERO2;
      mplier_q    <= ZERO;
      cnt_q       <= CNT_ZERO;
      out_q       <= ZERO;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = out_q;
  assign bus.alu_zero  = zero_q;
  assign bus.alu_carry = carry_q;
  assign bus.alu_neg   = neg_q;
  assign bus.alu_ovf   = ovf_q;
  assign bus.alu_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases with literal
// expectations plus random traffic compared every cycle against an arithmetic model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int MASK = FULL - 1;

  typedef struct {
    int out;
    int zero;
    int carry;
    int neg;
    int ovf;
    int err;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t q[$];
  exp_t last = '{0, 0, 0, 0, 0, 0, 0};
  exp_t cmp_cur;
  bit   cmp_ov;
  exp_t r;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  function automatic int out_of_range(input int s);
    return ((s > HALF - 1) || (s < -HALF)) ? 1 : 0;
  endfunction

  // What the ALU must return for one operation, from plain integer arithmetic.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int   res;
    e = '{0, 0, 0, 0, 0, 0, 2};
    res = 0;
    case (op)
      1:  begin res = a + b; e.carry = (res >= FULL); e.ovf = out_of_range(sgn(a) + sgn(b)); end
      2:  begin res = a - b; e.carry = (a < b);       e.ovf = out_of_range(sgn(a) - sgn(b)); end
      3:  begin res = a + 1; e.carry = (a == MASK);   e.ovf = out_of_range(sgn(a) + 1); end
      4:  begin res = a - 1; e.carry = (a == 0);      e.ovf = out_of_range(sgn(a) - 1); end
      5:  res = a | b;
      6:  res = a & b;
      7:  res = a ^ b;
      8:  begin res = a / 2; e.carry = a % 2; end
      9:  begin res = a * 2; e.carry = (a >= HALF); end
      10: res = MASK - a;
      11: begin res = FULL - a; e.carry = (a == 0); end
      12: begin res = a * b; e.carry = (res >= FULL); e.lat = W + 2; end
      default: begin res = 0; e.err = 1; end
    endcase
    e.out  = res & MASK;
    e.zero = (e.out == 0);
    e.neg  = (e.out >= HALF);
    return e;
  endfunction

  // Scoreboard: record accepted operations, retire them on the output handshake.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      last <= '{0, 0, 0, 0, 0, 0, 0};
      cyc  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        last <= q[0];
        q.pop_front();
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(int'(bus.opcode), int'(bus.in_a), int'(bus.in_b)));
        acc_cyc <= cyc;
      end
    end
  end

  // Every cycle: handshake signals and all outputs against the model.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      cmp_ov  = (q.size() != 0) && ((cyc - acc_cyc) >= q[0].lat);
      cmp_cur = cmp_ov ? q[0] : last;
      chk("in_ready", int'(bus.in_ready), int'(q.size() == 0));
      chk("out_valid", int'(bus.out_valid), int'(cmp_ov));
      chk("alu_out", int'(bus.alu_out), cmp_cur.out);
      chk("alu_zero", int'(bus.alu_zero), cmp_cur.zero);
      chk("alu_carry", int'(bus.alu_carry), cmp_cur.carry);
      chk("alu_neg", int'(bus.alu_neg), cmp_cur.neg);
      chk("alu_ovf", int'(bus.alu_ovf), cmp_cur.ovf);
      chk("alu_err", int'(bus.alu_err), cmp_cur.err);
    end
  end

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Issue one op from a negedge, scramble inputs after accept, return at the
  // negedge where out_valid first shows, with lat = edges from accept onward.
  task automatic do_op(input int op, input int a, input int b, output exp_t res);
    int waitc;
    waitc = 0;
    res = '{0, 0, 0, 0, 0, 0, 0};
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    bus.opcode   = 4'(op);
    bus.in_a     = 8'(a);
    bus.in_b     = 8'(b);
    bus.in_valid = 1'b1;
    @(posedge clk);
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      bus.opcode   = 4'($urandom);
      res.lat++;
    end while (!bus.out_valid && res.lat < 40);
    if (!bus.out_valid) chk("result_timeout", 0, 1);
    res.out   = int'(bus.alu_out);
    res.zero  = int'(bus.alu_zero);
    res.carry = int'(bus.alu_carry);
    res.neg   = int'(bus.alu_neg);
    res.ovf   = int'(bus.alu_ovf);
    res.err   = int'(bus.alu_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.opcode    = 4'h0;
    reset_n       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_alu_out", int'(bus.alu_out), 0);
    chk("rst_flags", int'({bus.alu_zero, bus.alu_carry, bus.alu_neg, bus.alu_ovf, bus.alu_err}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(1, 'hF0, 'h20, r);
    chk("add_f0_20_out", r.out, 'h10);
    chk("add_f0_20_carry", r.carry, 1);
    chk("add_f0_20_zero", r.zero, 0);
    chk("add_f0_20_ovf", r.ovf, 0);
    do_op(1, 'h7F, 'h01, r);
    chk("add_7f_01_out", r.out, 'h80);
    chk("add_7f_01_ovf", r.ovf, 1);
    chk("add_7f_01_neg", r.neg, 1);
    chk("add_lat", r.lat, 2);
    do_op(2, 'h05, 'h07, r);
    chk("sub_05_07_out", r.out, 'hFE);
    chk("sub_05_07_carry", r.carry, 1);
    chk("sub_05_07_neg", r.neg, 1);
    do_op(4, 'h00, 'h00, r);
    chk("dec_00_out", r.out, 'hFF);
    chk("dec_00_carry", r.carry, 1);
    do_op(11, 'h00, 'h00, r);
    chk("twos_00_out", r.out, 'h00);
    chk("twos_00_carry", r.carry, 1);
    chk("twos_00_zero", r.zero, 1);
    do_op(12, 'h0C, 'h0D, r);
    chk("mul_0c_0d_out", r.out, 'h9C);
    chk("mul_0c_0d_carry", r.carry, 0);
    chk("mul_lat", r.lat, 10);
    do_op(12, 'h10, 'h10, r);
    chk("mul_10_10_out", r.out, 'h00);
    chk("mul_10_10_carry", r.carry, 1);
    chk("mul_10_10_zero", r.zero, 1);
    do_op(7, 'hA5, 'h3C, r);
    chk("xor_out", r.out, 'h99);

    // Reset in the middle of a multiply discards it and clears the outputs.
    @(negedge clk);
    bus.opcode   = 4'hC;
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_alu_out", int'(bus.alu_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Held result under backpressure; new requests ignored meanwhile.
    bus.out_ready = 1'b0;
    do_op(1, 'h21, 'h12, r);
    chk("bp_first_out", r.out, 'h33);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = 4'h5;
      bus.in_a     = 8'hFF;
      bus.in_b     = 8'hFF;
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_alu_out", int'(bus.alu_out), 'h33);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_ready", int'(bus.in_ready), 1);
    chk("bp_hold_out", int'(bus.alu_out), 'h33);

    do_op(14, 'h12, 'h34, r);
    chk("ill_e_err", r.err, 1);
    chk("ill_e_out", r.out, 'h00);
    chk("ill_e_zero", r.zero, 1);
    chk("ill_lat", r.lat, 2);
    do_op(5, 'h0F, 'hF0, r);
    chk("or_after_err_out", r.out, 'hFF);
    chk("or_after_err_err", r.err, 0);

    // Random traffic with random backpressure; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.opcode    = 4'($urandom_range(0, 15));
      bus.in_a      = pick_val();
      bus.in_b      = pick_val();
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
